// File: rtl/regbank.sv
// rtl/regbank.sv - register bank with write-bypassed reads, per-register pending bits
// and a reset/clr-triggered sequential clear sweep
module regbank #(
  parameter int WIDTH    = 8,
  parameter int AW       = 4,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             we3,
  input  logic [AW-1:0]    WA3,
  input  logic [WIDTH-1:0] WD3,
  input  logic [AW-1:0]    RA1,
  input  logic [AW-1:0]    RA2,
  output logic [WIDTH-1:0] RD1,
  output logic [WIDTH-1:0] RD2,
  input  logic             mark,
  input  logic [AW-1:0]    mark_addr,
  output logic             pend1,
  output logic             pend2,
  output logic             busy
);

  localparam int DEPTH = 2 ** AW;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0] pend_q, pend_d;

  logic wr_en, mark_en;
  logic zero1, zero2, hit1, hit2;

  // Writes and marks only act in IDLE and never touch the hard-wired zero register.
  always_comb begin
    wr_en   = (state_q == IDLE) && we3 && !(ZERO_REG && (WA3 == '0));
    mark_en = (state_q == IDLE) && mark && !(ZERO_REG && (mark_addr == '0));
    zero1   = ZERO_REG && (RA1 == '0);
    zero2   = ZERO_REG && (RA2 == '0);
    hit1    = wr_en && (WA3 == RA1);
    hit2    = wr_en && (WA3 == RA2);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (clr) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (&cnt_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == CLEAR);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign busy = busy_q;

  always_comb begin
    mem_d = mem_q;
    if (state_q == CLEAR) begin
      mem_d[cnt_q] = '0;
    end else if (wr_en) begin
      mem_d[WA3] = WD3;
    end
  end

  // Storage has no reset value of its own; the sweep that follows reset defines it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_q <= mem_d;
    end
  end

  // Mark is applied after the write-clear so it wins on an address collision.
  always_comb begin
    pend_d = pend_q;
    if (wr_en) begin
      pend_d[WA3] = 1'b0;
    end
    if (mark_en) begin
      pend_d[mark_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  always_comb begin
    RD1   = '0;
    pend1 = 1'b0;
    if ((state_q == IDLE) && !zero1) begin
      RD1   = hit1 ? WD3 : mem_q[RA1];
      pend1 = pend_q[RA1] && !hit1;
    end
  end

  always_comb begin
    RD2   = '0;
    pend2 = 1'b0;
    if ((state_q == IDLE) && !zero2) begin
      RD2   = hit2 ? WD3 : mem_q[RA2];
      pend2 = pend_q[RA2] && !hit2;
    end
  end

endmodule

// File: tb/tb_regbank.sv
// tb/tb_regbank.sv - directed vector bench for regbank (default and WIDTH=16/AW=3 instances)
module tb_regbank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, clr, we3, mark;
  logic [3:0] WA3, RA1, RA2, mark_addr;
  logic [7:0] WD3, RD1, RD2;
  logic       pend1, pend2, busy;

  logic        b_reset, b_clr, b_we3, b_mark;
  logic [2:0]  b_WA3, b_RA1, b_RA2, b_mark_addr;
  logic [15:0] b_WD3, b_RD1, b_RD2;
  logic        b_pend1, b_pend2, b_busy;

  int checks = 0;
  int errors = 0;
  int cyc;

  regbank dut_a (
    .clk(clk), .reset(reset), .clr(clr), .we3(we3), .WA3(WA3), .WD3(WD3),
    .RA1(RA1), .RA2(RA2), .RD1(RD1), .RD2(RD2), .mark(mark), .mark_addr(mark_addr),
    .pend1(pend1), .pend2(pend2), .busy(busy)
  );

  regbank #(.WIDTH(16), .AW(3)) dut_b (
    .clk(clk), .reset(b_reset), .clr(b_clr), .we3(b_we3), .WA3(b_WA3), .WD3(b_WD3),
    .RA1(b_RA1), .RA2(b_RA2), .RD1(b_RD1), .RD2(b_RD2), .mark(b_mark), .mark_addr(b_mark_addr),
    .pend1(b_pend1), .pend2(b_pend2), .busy(b_busy)
  );

  typedef struct {
    logic       we3;
    logic [3:0] wa;
    logic [7:0] wd;
    logic       mark;
    logic [3:0] ma;
    logic [3:0] ra1;
    logic [3:0] ra2;
    logic [7:0] rd1;
    logic [7:0] rd2;
    logic       p1;
    logic       p2;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    clr = 1'b0; we3 = 1'b0; mark = 1'b0;
    WA3 = '0; WD3 = '0; mark_addr = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b1, 4'd5,  8'hA7, 1'b0, 4'd0, 4'd5, 4'd5,  8'hA7, 8'hA7, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 4'd0,  8'h00, 1'b0, 4'd0, 4'd5, 4'd0,  8'hA7, 8'h00, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 4'd0,  8'hFF, 1'b1, 4'd0, 4'd0, 4'd5,  8'h00, 8'hA7, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 4'd0,  8'h00, 1'b1, 4'd3, 4'd0, 4'd3,  8'h00, 8'h00, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 4'd0,  8'h00, 1'b0, 4'd0, 4'd5, 4'd3,  8'hA7, 8'h00, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 4'd3,  8'h11, 1'b0, 4'd0, 4'd3, 4'd3,  8'h11, 8'h11, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 4'd7,  8'h22, 1'b1, 4'd7, 4'd7, 4'd3,  8'h22, 8'h11, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 4'd10, 8'h3C, 1'b1, 4'd9, 4'd7, 4'd10, 8'h22, 8'h3C, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 4'd0,  8'h00, 1'b0, 4'd0, 4'd9, 4'd10, 8'h00, 8'h3C, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 4'd9,  8'h55, 1'b0, 4'd0, 4'd9, 4'd15, 8'h55, 8'h00, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 4'd0,  8'h00, 1'b0, 4'd0, 4'd9, 4'd9,  8'h55, 8'h55, 1'b0, 1'b0};

    reset = 1'b0; idle_inputs(); RA1 = '0; RA2 = '0;
    b_reset = 1'b0; b_clr = 1'b0; b_we3 = 1'b0; b_mark = 1'b0;
    b_WA3 = '0; b_WD3 = '0; b_RA1 = '0; b_RA2 = '0; b_mark_addr = '0;

    // Small instance: 8-register sweep after a one-cycle reset
    @(negedge clk); b_reset = 1'b1;
    @(posedge clk); #1; b_reset = 1'b0;
    chk("b_reset_busy", 32'(b_busy), 32'd1);
    cyc = 0;
    while (b_busy && cyc < 64) begin
      @(posedge clk); #1; cyc++;
    end
    chk("b_sweep_len", cyc, 32'd8);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); b_RA1 = 3'(i); #1;
      chk($sformatf("b_zero_rd1[%0d]", i), 32'(b_RD1), 32'd0);
    end
    @(negedge clk); b_we3 = 1'b1; b_WA3 = 3'd7; b_WD3 = 16'hBEEF; b_RA1 = 3'd7; #1;
    chk("b_bypass16", 32'(b_RD1), 32'h0000BEEF);
    @(posedge clk); #1; b_we3 = 1'b0;
    @(negedge clk); #1;
    chk("b_store16", 32'(b_RD1), 32'h0000BEEF);

    // Default instance: reset sweep, then all registers zero
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    chk("a_reset_busy", 32'(busy), 32'd1);
    chk("a_reset_rd1", 32'(RD1), 32'd0);
    cyc = 0;
    while (busy && cyc < 64) begin
      @(posedge clk); #1; cyc++;
    end
    chk("a_sweep_len", cyc, 32'd16);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); RA1 = 4'(i); #1;
      chk($sformatf("a_zero_rd1[%0d]", i), 32'(RD1), 32'd0);
      chk($sformatf("a_zero_pend1[%0d]", i), 32'(pend1), 32'd0);
    end

    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      we3 = vecs[i].we3; WA3 = vecs[i].wa; WD3 = vecs[i].wd;
      mark = vecs[i].mark; mark_addr = vecs[i].ma;
      RA1 = vecs[i].ra1; RA2 = vecs[i].ra2;
      #1;
      chk($sformatf("vec%0d_rd1", i), 32'(RD1), 32'(vecs[i].rd1));
      chk($sformatf("vec%0d_rd2", i), 32'(RD2), 32'(vecs[i].rd2));
      chk($sformatf("vec%0d_pend1", i), 32'(pend1), 32'(vecs[i].p1));
      chk($sformatf("vec%0d_pend2", i), 32'(pend2), 32'(vecs[i].p2));
      @(posedge clk); #1;
    end
    idle_inputs();

    // clr sweep: writes, marks and a second clr during the sweep are all ignored
    @(negedge clk); clr = 1'b1; RA1 = 4'd9; RA2 = 4'd9;
    @(posedge clk); #1; clr = 1'b0;
    chk("clr_busy", 32'(busy), 32'd1);
    cyc = 0;
    while (busy && cyc < 64) begin
      @(negedge clk);
      we3 = (cyc == 2) || (cyc == 12);
      WA3 = (cyc == 12) ? 4'd1 : 4'd9;
      WD3 = 8'h66;
      clr = (cyc == 4);
      mark = (cyc == 3);
      mark_addr = 4'd4;
      #1;
      if (cyc == 2) begin
        chk("sweep_no_bypass", 32'(RD1), 32'd0);
        chk("sweep_busy_c2", 32'(busy), 32'd1);
      end
      @(posedge clk); #1; cyc++;
    end
    idle_inputs();
    chk("clr_sweep_len", cyc, 32'd16);
    @(negedge clk); RA1 = 4'd9; RA2 = 4'd1; #1;
    chk("r9_cleared", 32'(RD1), 32'd0);
    chk("r1_write_ignored", 32'(RD2), 32'd0);
    @(negedge clk); RA2 = 4'd4; #1;
    chk("mark_ignored", 32'(pend2), 32'd0);

    // Reset mid-sweep restarts the count; reset beats a same-cycle mark
    @(negedge clk); mark = 1'b1; mark_addr = 4'd6; we3 = 1'b1; WA3 = 4'd15; WD3 = 8'h5A;
    @(posedge clk); #1; idle_inputs();
    @(negedge clk); RA1 = 4'd6; RA2 = 4'd15; #1;
    chk("pend6_set", 32'(pend1), 32'd1);
    chk("r15_written", 32'(RD2), 32'h5A);
    @(negedge clk); reset = 1'b1; mark = 1'b1; mark_addr = 4'd5; clr = 1'b1;
    @(posedge clk); #1; reset = 1'b0; idle_inputs();
    cyc = 0;
    while (busy && cyc < 8) begin
      @(posedge clk); #1; cyc++;
    end
    chk("pre_restart_cycles", cyc, 32'd8);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    cyc = 0;
    while (busy && cyc < 64) begin
      @(posedge clk); #1; cyc++;
    end
    chk("restart_sweep_len", cyc, 32'd16);
    @(negedge clk); RA1 = 4'd6; RA2 = 4'd15; #1;
    chk("pend6_reset", 32'(pend1), 32'd0);
    chk("r15_cleared", 32'(RD2), 32'd0);
    @(negedge clk); RA2 = 4'd5; #1;
    chk("reset_beats_mark", 32'(pend2), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regbank.md
REGBANK -- requirements
Module: regbank

Interface
REQ-001 Parameter WIDTH, default 8, data width of each register in bits.
REQ-002 Parameter AW, default 4, address width; DEPTH = 2**AW registers.
REQ-003 Parameter ZERO_REG, default 1, when 1 register 0 reads as zero and is never written or marked pending.
REQ-004 Port clk  input  1  clock; all state changes on rising edge.
REQ-005 Port reset  input  1  reset, synchronous and active-high.
REQ-006 Port clr  input  1  request to start a sequential clear of all registers.
REQ-007 Port we3  input  1  write enable.
REQ-008 Port WA3  input  AW  write address.
REQ-009 Port WD3  input  WIDTH  write data.
REQ-010 Port RA1, RA2  input  AW each  read addresses.
REQ-011 Port RD1, RD2  output  WIDTH each  read data, combinational.
REQ-012 Port mark  input  1  set pending bit of register mark_addr.
REQ-013 Port mark_addr  input  AW  register to mark pending.
REQ-014 Port pend1, pend2  output  1 each  pending status of RA1/RA2, combinational.
REQ-015 Port busy  output  1  high while the clear sequence runs.

Function
REQ-016 FSM states IDLE and CLEAR, plus an AW-bit clear counter cnt.
REQ-017 IDLE -> CLEAR when clr=1, with cnt loaded to 0; otherwise stay IDLE.
REQ-018 In CLEAR, each cycle writes 0 to register cnt and increments cnt; when cnt=DEPTH-1 the write occurs and state returns to IDLE (DEPTH cycles total).
REQ-019 clr asserted in CLEAR is ignored; the sweep does not restart.
REQ-020 busy = 1 exactly while state is CLEAR.
REQ-021 In CLEAR, we3 and mark are ignored; RD1, RD2, pend1, pend2 are 0.
REQ-022 In IDLE, we3=1 writes WD3 to register WA3 at the edge; if ZERO_REG=1 and WA3=0, no write.
REQ-023 Read: RDn = register RAn; 0 if ZERO_REG=1 and RAn=0.
REQ-024 Bypass: in IDLE, if we3=1 and WA3=RAn (and not the zero register), RDn = WD3 in the same cycle.
REQ-025 Pending bits: DEPTH bits; mark=1 sets pend[mark_addr]; we3=1 clears pend[WA3]; both on the rising edge, IDLE only.
REQ-026 Simultaneous mark and we3 on same address: bit ends set (mark wins); different addresses: both actions apply.
REQ-027 pendn = pend[RAn] AND NOT (bypass hit on RAn per REQ-024); 0 for zero register when ZERO_REG=1.
REQ-028 Both read ports may address the same register; outputs are then identical.
REQ-029 Counter and addresses are unsigned; no wrap beyond DEPTH-1 occurs since CLEAR exits there.

Reset
REQ-030 reset=1 at a rising edge forces state CLEAR, cnt=0, all pending bits 0, regardless of current state (including mid-sweep, which restarts at 0).
REQ-031 After reset deasserts, busy=1 for DEPTH cycles, then all registers read 0 and busy=0.
REQ-032 reset has priority over clr, we3 and mark in the same cycle.
REQ-033 Register contents have no initial value; only the reset-triggered sweep defines them.

Verification
REQ-034 Reset 1 cycle, defaults -> busy=1 for 16 cycles, then busy=0; RD1 for RA1=0..15 all 0x00.
REQ-035 IDLE, we3=1 WA3=5 WD3=0xA7, RA1=5 same cycle -> RD1=0xA7 (bypass); next cycle we3=0 -> RD1=0xA7 from storage.
REQ-036 we3=1 WA3=0 WD3=0xFF, mark=1 mark_addr=0 -> RD1(RA1=0)=0x00, pend1=0 next cycle.
REQ-037 mark=1 addr=3; next cycle RA2=3 -> pend2=1; then we3=1 WA3=3 WD3=0x11 -> pend2=0 same cycle (bypass), pend bit clear next cycle; mark and we3 both on addr 7 same edge -> pend[7]=1.
REQ-038 Write 0x55 to r9, pulse clr, assert we3 WA3=9 WD3=0x66 at sweep cycle 2 and clr again at cycle 4 -> write ignored, sweep not restarted, busy low after exactly 16 cycles, r9 reads 0x00.
REQ-039 Reset asserted at sweep cycle 8 -> cnt restarts at 0, busy stays high 16 further cycles after reset release; WIDTH=16, AW=3 instance repeats REQ-034 with 8-cycle sweep.
